dma_datapath_prims: RTL and testbench
=====================================

DMA_DATAPATH_PRIMS -- requirements
Module: dma_datapath_prims

Interface
REQ-001 Parameter DATA, default 8: FIFO word width.
REQ-002 Parameter ADDR_SIZE, default 4: FIFO holds 2^ADDR_SIZE words.
REQ-003 Parameter DIV_FACTOR, default 3: partial-empty threshold is 2^ADDR_SIZE >> DIV_FACTOR words (default 2).
REQ-004 Parameter L, default 5: counter width.
REQ-005 Parameter REG_DEPTH, default 8: register width.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high; clears all three units.
REQ-008 fifo_rst  in  1  synchronous FIFO clear.
REQ-009 fifo_enable  in  1  perform one FIFO operation this cycle.
REQ-010 fifo_wr_rd  in  1  1 = write, 0 = read.
REQ-011 fifo_old_add_flag  in  1  retry request: rewind the selected pointer.
REQ-012 fifo_in  in  DATA  write data.
REQ-013 fifo_out  out  DATA  word at read pointer, combinational (first-word-fall-through).
REQ-014 full / empty / empty_partial  out  1 each  FIFO status, combinational from the occupancy count.
REQ-015 cnt_rst, cnt_load, cnt_en  in  1 each  counter clear, load, enable.
REQ-016 cnt_data_in  in  L  load value.
REQ-017 cnt  out  L  count value.
REQ-018 end_cnt  out  1  counter terminal flag.
REQ-019 reg_rst, reg_en  in  1 each  register clear, enable.
REQ-020 reg_data_in  in  REG_DEPTH  register input.
REQ-021 reg_data_out  out  REG_DEPTH  register contents.

Function
REQ-022 FIFO: write pointer, read pointer and occupancy count (ADDR_SIZE+1 bits) are kept internally; pointers wrap modulo 2^ADDR_SIZE.
REQ-023 FIFO write (enable=1, wr_rd=1, flag=0, not full): mem[wr_ptr] gets fifo_in; wr_ptr+1; count+1.
REQ-024 FIFO write while full is ignored; all state is unchanged.
REQ-025 FIFO read (enable=1, wr_rd=0, flag=0, not empty): rd_ptr+1; count-1.
REQ-026 FIFO read while empty is ignored.
REQ-027 full = (count == 2^ADDR_SIZE).
REQ-028 empty = (count == 0).
REQ-029 empty_partial = (count <= 2^ADDR_SIZE >> DIV_FACTOR).
REQ-030 Retry: on the first cycle that fifo_old_add_flag is high (flag was low the previous cycle), the pointer selected by wr_rd is decremented by one.
  - Write rewind (wr_rd=1): discard the last write; count-1 (no effect if empty).
  - Read rewind (wr_rd=0): re-present the last read word; count+1 (no effect if full).
REQ-031 While fifo_old_add_flag is high, fifo_enable is ignored and no further pointer change occurs.
REQ-032 fifo_rst or rst: both pointers and count go to 0; memory contents are not required to clear; fifo_out after clear is don't-care.
REQ-033 Counter priority, highest first:
  - rst or cnt_rst: cnt goes to 0.
  - cnt_en & cnt_load: cnt takes cnt_data_in.
  - cnt_en: cnt+1, wrapping from all-ones to 0.
  - otherwise: hold.
REQ-034 cnt_load without cnt_en has no effect.
REQ-035 end_cnt = (cnt == all-ones), combinational.
REQ-036 Register priority: rst or reg_rst gives 0; otherwise reg_en loads reg_data_in; otherwise hold.
REQ-037 The three units are independent; activity in one never affects another.

Reset
REQ-038 After rst:
  - FIFO: count = 0, empty = 1, empty_partial = 1, full = 0.
  - Counter: cnt = 0, end_cnt = 0.
  - Register: reg_data_out = 0.
REQ-039 rst asserted mid-operation overrides every other input in that cycle; a write, read or load issued in that cycle is lost.

Verification
REQ-040 Write 0x11..0x1F then 0x20 (16 words) -> full = 1 after the 16th write; a 17th write of 0xFF is ignored; 16 reads return 0x11..0x20 in order; empty = 1 afterwards.
REQ-041 Write 3 words -> empty_partial = 0; read 1 -> empty_partial = 1 (count 2); read 2 -> empty = 1.
REQ-042 Write A, B, then flag=1 with wr_rd=1 held 3 cycles -> count = 1, next write C lands after A; reads give A, C.
REQ-043 Write A, B, read A, then flag=1 with wr_rd=0 -> fifo_out = A again, count = 2.
REQ-044 Counter (L=5): cnt_en=1 for 31 cycles -> cnt = 31, end_cnt = 1; next cycle cnt = 0; cnt_load=1 with cnt_en=0 and cnt_data_in=1 -> no change; cnt_load=1 with cnt_en=1 -> cnt = 1; cnt_rst together with cnt_en -> cnt = 0.
REQ-045 Register: reg_en=1 with input 0xA5 -> 0xA5; reg_en=0 with input 0x3C -> holds 0xA5; rst together with reg_en -> 0x00.

Source files
------------

// File: rtl/dma_datapath_prims_if.sv
// Bundles the FIFO, counter and register control/data signals of dma_datapath_prims.
// The master side drives controls and data; the slave side (the datapath) returns status and data.
interface dma_datapath_prims_if #(
    parameter int DATA      = 8,
    parameter int L         = 5,
    parameter int REG_DEPTH = 8
);
    logic                 fifo_rst;
    logic                 fifo_enable;
    logic                 fifo_wr_rd;
    logic                 fifo_old_add_flag;
    logic [DATA-1:0]      fifo_in;
    logic [DATA-1:0]      fifo_out;
    logic                 full;
    logic                 empty;
    logic                 empty_partial;

    logic                 cnt_rst;
    logic                 cnt_load;
    logic                 cnt_en;
    logic [L-1:0]         cnt_data_in;
    logic [L-1:0]         cnt;
    logic                 end_cnt;

    logic                 reg_rst;
    logic                 reg_en;
    logic [REG_DEPTH-1:0] reg_data_in;
    logic [REG_DEPTH-1:0] reg_data_out;

    modport master (
        output fifo_rst, fifo_enable, fifo_wr_rd, fifo_old_add_flag, fifo_in,
        input  fifo_out, full, empty, empty_partial,
        output cnt_rst, cnt_load, cnt_en, cnt_data_in,
        input  cnt, end_cnt,
        output reg_rst, reg_en, reg_data_in,
        input  reg_data_out
    );

    modport slave (
        input  fifo_rst, fifo_enable, fifo_wr_rd, fifo_old_add_flag, fifo_in,
        output fifo_out, full, empty, empty_partial,
        input  cnt_rst, cnt_load, cnt_en, cnt_data_in,
        output cnt, end_cnt,
        input  reg_rst, reg_en, reg_data_in,
        output reg_data_out
    );
endinterface

// File: rtl/dma_datapath_prims.sv
// DMA datapath primitives: retry-capable FIFO, loadable wrap counter, enable register.
// Latency: one cycle for every state update; fifo_out and all status flags are combinational.
// Backpressure: writes while full and reads while empty are dropped; callers must watch full/empty.
module dma_datapath_prims #(
    parameter int DATA       = 8,
    parameter int ADDR_SIZE  = 4,
    parameter int DIV_FACTOR = 3,
    parameter int L          = 5,
    parameter int REG_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dma_datapath_prims_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] PART_TH  = (ADDR_SIZE+1)'(DEPTH >> DIV_FACTOR);

    // ---------------- FIFO ----------------
    logic [DATA-1:0]      r_mem [0:DEPTH-1];
    logic [ADDR_SIZE-1:0] r_wr_ptr;
    logic [ADDR_SIZE-1:0] r_rd_ptr;
    logic [ADDR_SIZE:0]   r_count;
    logic                 r_flag_q;

    logic w_full;
    logic w_empty;
    logic w_flag_rise;
    logic w_do_write;
    logic w_do_read;
    logic w_rewind_wr;
    logic w_rewind_rd;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_flag_rise = bus.fifo_old_add_flag & ~r_flag_q;

    // Normal traffic is suppressed for the whole time the retry flag is high.
    assign w_do_write  = bus.fifo_enable & ~bus.fifo_old_add_flag &  bus.fifo_wr_rd & ~w_full;
    assign w_do_read   = bus.fifo_enable & ~bus.fifo_old_add_flag & ~bus.fifo_wr_rd & ~w_empty;
    assign w_rewind_wr = w_flag_rise &  bus.fifo_wr_rd & ~w_empty;
    assign w_rewind_rd = w_flag_rise & ~bus.fifo_wr_rd & ~w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_q <= 1'b0;
        end else begin
            r_flag_q <= bus.fifo_old_add_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.fifo_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_rewind_wr) begin
            r_wr_ptr <= r_wr_ptr - ADDR_SIZE'(1);
            r_count  <= r_count - (ADDR_SIZE+1)'(1);
        end else if (w_rewind_rd) begin
            r_rd_ptr <= r_rd_ptr - ADDR_SIZE'(1);
            r_count  <= r_count + (ADDR_SIZE+1)'(1);
        end else if (w_do_write) begin
            r_wr_ptr <= r_wr_ptr + ADDR_SIZE'(1);
            r_count  <= r_count + (ADDR_SIZE+1)'(1);
        end else if (w_do_read) begin
            r_rd_ptr <= r_rd_ptr + ADDR_SIZE'(1);
            r_count  <= r_count - (ADDR_SIZE+1)'(1);
        end
    end

    // Storage is never cleared; reset only empties it through the pointers.
    always_ff @(posedge clk) begin
        if (!rst && !bus.fifo_rst && w_do_write) begin
            r_mem[r_wr_ptr] <= bus.fifo_in;
        end
    end

    assign bus.fifo_out      = r_mem[r_rd_ptr];
    assign bus.full          = w_full;
    assign bus.empty         = w_empty;
    assign bus.empty_partial = (r_count <= PART_TH);

    // ---------------- Counter ----------------
    logic [L-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || bus.cnt_rst) begin
            r_cnt <= '0;
        end else if (bus.cnt_en && bus.cnt_load) begin
            r_cnt <= bus.cnt_data_in;
        end else if (bus.cnt_en) begin
            r_cnt <= r_cnt + L'(1);
        end
    end

    assign bus.cnt     = r_cnt;
    assign bus.end_cnt = &r_cnt;

    // ---------------- Register ----------------
    logic [REG_DEPTH-1:0] r_reg;

    always_ff @(posedge clk) begin
        if (rst || bus.reg_rst) begin
            r_reg <= '0;
        end else if (bus.reg_en) begin
            r_reg <= bus.reg_data_in;
        end
    end

    assign bus.reg_data_out = r_reg;

endmodule

// File: tb/tb_dma_datapath_prims.sv
// Directed bench for dma_datapath_prims: FIFO fill/drain, thresholds, both retry modes, counter and register.
module tb_dma_datapath_prims;
    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    dma_datapath_prims_if #(.DATA(8), .L(5), .REG_DEPTH(8)) bus ();

    dma_datapath_prims #(
        .DATA(8), .ADDR_SIZE(4), .DIV_FACTOR(3), .L(5), .REG_DEPTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] v);
        bus.fifo_enable = 1'b1;
        bus.fifo_wr_rd  = 1'b1;
        bus.fifo_in     = v;
        step();
        bus.fifo_enable = 1'b0;
    endtask

    task automatic rd();
        bus.fifo_enable = 1'b1;
        bus.fifo_wr_rd  = 1'b0;
        step();
        bus.fifo_enable = 1'b0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst = 1'b1;
        bus.fifo_rst = 0; bus.fifo_enable = 0; bus.fifo_wr_rd = 0;
        bus.fifo_old_add_flag = 0; bus.fifo_in = '0;
        bus.cnt_rst = 0; bus.cnt_load = 0; bus.cnt_en = 0; bus.cnt_data_in = '0;
        bus.reg_rst = 0; bus.reg_en = 0; bus.reg_data_in = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_empty",   32'(bus.empty),         32'd1);
        chk("rst_partial", 32'(bus.empty_partial), 32'd1);
        chk("rst_full",    32'(bus.full),          32'd0);
        chk("rst_cnt",     32'(bus.cnt),           32'd0);
        chk("rst_end_cnt", 32'(bus.end_cnt),       32'd0);
        chk("rst_reg",     32'(bus.reg_data_out),  32'd0);

        // Fill to full, overflow attempt, drain in order
        for (int i = 0; i < 16; i++) begin
            chk("fill_not_full", 32'(bus.full), 32'd0);
            wr(8'(8'h11 + i));
        end
        chk("fill_full",  32'(bus.full),  32'd1);
        chk("fill_empty", 32'(bus.empty), 32'd0);
        wr(8'hFF);
        chk("ovf_full", 32'(bus.full),     32'd1);
        chk("ovf_head", 32'(bus.fifo_out), 32'h11);
        for (int i = 0; i < 16; i++) begin
            chk("drain_data", 32'(bus.fifo_out), 32'(8'h11 + i));
            rd();
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_full",  32'(bus.full),  32'd0);
        rd();
        chk("udf_empty", 32'(bus.empty), 32'd1);

        // Partial-empty threshold (2 words)
        wr(8'h31);
        wr(8'h32);
        chk("part_cnt2", 32'(bus.empty_partial), 32'd1);
        wr(8'h33);
        chk("part_cnt3", 32'(bus.empty_partial), 32'd0);
        rd();
        chk("part_rd1", 32'(bus.empty_partial), 32'd1);
        chk("part_rd1_empty", 32'(bus.empty), 32'd0);
        chk("part_head", 32'(bus.fifo_out), 32'h32);
        rd();
        rd();
        chk("part_empty", 32'(bus.empty), 32'd1);

        // Write rewind: enable held high during the flag must be ignored
        wr(8'hA1);
        wr(8'hB2);
        bus.fifo_old_add_flag = 1'b1;
        bus.fifo_wr_rd  = 1'b1;
        bus.fifo_enable = 1'b1;
        bus.fifo_in     = 8'hEE;
        step();
        step();
        step();
        bus.fifo_old_add_flag = 1'b0;
        bus.fifo_enable = 1'b0;
        wr(8'hC3);
        chk("wrw_head", 32'(bus.fifo_out), 32'hA1);
        rd();
        chk("wrw_second", 32'(bus.fifo_out), 32'hC3);
        rd();
        chk("wrw_empty", 32'(bus.empty), 32'd1);

        // FIFO clear
        wr(8'h77);
        wr(8'h78);
        bus.fifo_rst = 1'b1;
        step();
        bus.fifo_rst = 1'b0;
        chk("frst_empty", 32'(bus.empty), 32'd1);

        // Read rewind: re-present last word, holding flag gives only one rewind
        wr(8'h5A);
        wr(8'h6B);
        chk("rrw_head", 32'(bus.fifo_out), 32'h5A);
        rd();
        chk("rrw_after_rd", 32'(bus.fifo_out), 32'h6B);
        bus.fifo_old_add_flag = 1'b1;
        bus.fifo_wr_rd = 1'b0;
        step();
        chk("rrw_replay", 32'(bus.fifo_out), 32'h5A);
        step();
        chk("rrw_hold", 32'(bus.fifo_out), 32'h5A);
        bus.fifo_old_add_flag = 1'b0;
        chk("rrw_partial", 32'(bus.empty_partial), 32'd1);
        rd();
        chk("rrw_second", 32'(bus.fifo_out), 32'h6B);
        chk("rrw_not_empty", 32'(bus.empty), 32'd0);
        rd();
        chk("rrw_empty", 32'(bus.empty), 32'd1);

        // rst wins over a write in the same cycle
        rst = 1'b1;
        wr(8'h99);
        rst = 1'b0;
        chk("rst_drop_wr", 32'(bus.empty), 32'd1);

        // Counter
        chk("cnt_start", 32'(bus.cnt), 32'd0);
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 31; i++) step();
        chk("cnt_31",  32'(bus.cnt),     32'd31);
        chk("cnt_end", 32'(bus.end_cnt), 32'd1);
        step();
        chk("cnt_wrap",     32'(bus.cnt),     32'd0);
        chk("cnt_wrap_end", 32'(bus.end_cnt), 32'd0);
        bus.cnt_en = 1'b0;
        bus.cnt_load = 1'b1;
        bus.cnt_data_in = 5'd1;
        step();
        chk("cnt_load_no_en", 32'(bus.cnt), 32'd0);
        bus.cnt_en = 1'b1;
        step();
        chk("cnt_load_en", 32'(bus.cnt), 32'd1);
        bus.cnt_data_in = 5'd20;
        step();
        bus.cnt_load = 1'b0;
        step();
        chk("cnt_load_inc", 32'(bus.cnt), 32'd21);
        bus.cnt_rst = 1'b1;
        step();
        bus.cnt_rst = 1'b0;
        bus.cnt_en = 1'b0;
        chk("cnt_rst_en", 32'(bus.cnt), 32'd0);
        step();
        chk("cnt_hold", 32'(bus.cnt), 32'd0);

        // Register
        bus.reg_en = 1'b1;
        bus.reg_data_in = 8'hA5;
        step();
        chk("reg_load", 32'(bus.reg_data_out), 32'hA5);
        bus.reg_en = 1'b0;
        bus.reg_data_in = 8'h3C;
        step();
        chk("reg_hold", 32'(bus.reg_data_out), 32'hA5);
        chk("reg_indep_cnt", 32'(bus.cnt), 32'd0);
        bus.reg_rst = 1'b1;
        bus.reg_en = 1'b1;
        step();
        bus.reg_rst = 1'b0;
        chk("reg_rst", 32'(bus.reg_data_out), 32'h00);
        step();
        chk("reg_load2", 32'(bus.reg_data_out), 32'h3C);
        bus.reg_data_in = 8'hFF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.reg_en = 1'b0;
        chk("reg_rst_over_en", 32'(bus.reg_data_out), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
